// File: rtl/cursor_ctrl.sv
// Mouse cursor controller: accumulates mouse packets and commits them to the cursor position once per frame.
// Optional feature: define CURSOR_WRAP_EN so out-of-range positions wrap instead of clamping.
module cursor_ctrl #(
    parameter int X_MAX    = 639,
    parameter int Y_MAX    = 479,
    parameter int CUR_SIZE = 20,
    parameter int X_INIT   = 130,
    parameter int Y_INIT   = 130
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [8:0]  xm,
    input  logic [8:0]  ym,
    input  logic [2:0]  btnm,
    input  logic        m_done_tick,
    input  logic        frame_tick,
    output logic [10:0] cursor_x,
    output logic [10:0] cursor_y,
    output logic [2:0]  cursor_rgb,
    output logic        pending,
    output logic [7:0]  pkt_count,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PEND   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam int X_LIM = X_MAX - CUR_SIZE + 1;
    localparam int Y_LIM = Y_MAX - CUR_SIZE + 1;

    state_t             state_q, state_d;
    logic signed [11:0] dx_q, dx_d, dy_q, dy_d;
    logic signed [11:0] snap_dx_q, snap_dx_d, snap_dy_q, snap_dy_d;
    logic [2:0]         btn_q, btn_d, snap_btn_q, snap_btn_d;
    logic               held_q, held_d;
    logic [10:0]        cursor_x_q, cursor_x_d, cursor_y_q, cursor_y_d;
    logic [2:0]         cursor_rgb_q, cursor_rgb_d;
    logic               pending_q, pending_d;
    logic [7:0]         pkt_count_q, pkt_count_d;

    logic signed [12:0] xm_delta, ym_delta;

    // Screen Y grows downward while mouse Y is positive upward.
    assign xm_delta = $signed({{4{xm[8]}}, xm});
    assign ym_delta = -$signed({{4{ym[8]}}, ym});

    function automatic logic signed [11:0] sat_add(input logic signed [11:0] acc,
                                                   input logic signed [12:0] delta);
        logic signed [12:0] sum;
        sum = $signed({acc[11], acc}) + delta;
        if (sum > 13'sd2047)
            return 12'sh7FF;
        else if (sum < -13'sd2048)
            return 12'sh800;
        else
            return sum[11:0];
    endfunction

    function automatic logic [2:0] colour(input logic [2:0] b);
        case (b)
            3'b001:  return 3'b010;
            3'b010:  return 3'b100;
            3'b100:  return 3'b000;
            default: return 3'b111;
        endcase
    endfunction

`ifdef CURSOR_WRAP_EN
    function automatic logic [10:0] new_pos(input logic [10:0] old,
                                            input logic signed [11:0] d,
                                            input int lim);
        logic signed [12:0] sum;
        int                 v;
        int                 rng;
        sum = $signed({2'b00, old}) + $signed({d[11], d});
        rng = lim + 1;
        // Bias by a multiple of the range so the modulo always sees a non-negative value.
        v   = int'(sum) + rng * ((4096 + rng - 1) / rng);
        return 11'(v % rng);
    endfunction
`else
    function automatic logic [10:0] new_pos(input logic [10:0] old,
                                            input logic signed [11:0] d,
                                            input int lim);
        logic signed [12:0] sum;
        sum = $signed({2'b00, old}) + $signed({d[11], d});
        if (sum < 0)
            return 11'd0;
        else if (int'(sum) > lim)
            return 11'(lim);
        else
            return sum[10:0];
    endfunction
`endif

    always_comb begin
        state_d      = state_q;
        dx_d         = dx_q;
        dy_d         = dy_q;
        btn_d        = btn_q;
        snap_dx_d    = snap_dx_q;
        snap_dy_d    = snap_dy_q;
        snap_btn_d   = snap_btn_q;
        held_d       = held_q;
        cursor_x_d   = cursor_x_q;
        cursor_y_d   = cursor_y_q;
        cursor_rgb_d = cursor_rgb_q;
        pkt_count_d  = m_done_tick ? pkt_count_q + 8'd1 : pkt_count_q;

        if (m_done_tick)
            btn_d = btnm;

        case (state_q)
            IDLE: begin
                if (m_done_tick) begin
                    dx_d    = sat_add(12'sd0, xm_delta);
                    dy_d    = sat_add(12'sd0, ym_delta);
                    state_d = PEND;
                end
            end
            PEND: begin
                if (frame_tick) begin
                    snap_dx_d  = dx_q;
                    snap_dy_d  = dy_q;
                    snap_btn_d = btn_q;
                    state_d    = COMMIT;
                    // A packet coinciding with the frame tick starts the next batch.
                    if (m_done_tick) begin
                        dx_d   = sat_add(12'sd0, xm_delta);
                        dy_d   = sat_add(12'sd0, ym_delta);
                        held_d = 1'b1;
                    end else begin
                        dx_d   = 12'sd0;
                        dy_d   = 12'sd0;
                        held_d = 1'b0;
                    end
                end else if (m_done_tick) begin
                    dx_d = sat_add(dx_q, xm_delta);
                    dy_d = sat_add(dy_q, ym_delta);
                end
            end
            COMMIT: begin
                cursor_x_d   = new_pos(cursor_x_q, snap_dx_q, X_LIM);
                cursor_y_d   = new_pos(cursor_y_q, snap_dy_q, Y_LIM);
                cursor_rgb_d = colour(snap_btn_q);
                if (m_done_tick) begin
                    dx_d = sat_add(dx_q, xm_delta);
                    dy_d = sat_add(dy_q, ym_delta);
                end
                state_d = (held_q || m_done_tick) ? PEND : IDLE;
                held_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                held_d  = 1'b0;
            end
        endcase

        pending_d = (state_d == PEND) || ((state_d == COMMIT) && held_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            dx_q         <= 12'sd0;
            dy_q         <= 12'sd0;
            btn_q        <= 3'b000;
            snap_dx_q    <= 12'sd0;
            snap_dy_q    <= 12'sd0;
            snap_btn_q   <= 3'b000;
            held_q       <= 1'b0;
            cursor_x_q   <= 11'(X_INIT);
            cursor_y_q   <= 11'(Y_INIT);
            cursor_rgb_q <= 3'b111;
            pending_q    <= 1'b0;
            pkt_count_q  <= 8'd0;
        end else begin
            state_q      <= state_d;
            dx_q         <= dx_d;
            dy_q         <= dy_d;
            btn_q        <= btn_d;
            snap_dx_q    <= snap_dx_d;
            snap_dy_q    <= snap_dy_d;
            snap_btn_q   <= snap_btn_d;
            held_q       <= held_d;
            cursor_x_q   <= cursor_x_d;
            cursor_y_q   <= cursor_y_d;
            cursor_rgb_q <= cursor_rgb_d;
            pending_q    <= pending_d;
            pkt_count_q  <= pkt_count_d;
        end
    end

    assign cursor_x   = cursor_x_q;
    assign cursor_y   = cursor_y_q;
    assign cursor_rgb = cursor_rgb_q;
    assign pending    = pending_q;
    assign pkt_count  = pkt_count_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_cursor_ctrl.sv
// Directed testbench for cursor_ctrl with hand-computed expectations for both clamp and wrap builds.
module tb_cursor_ctrl;

    logic        clk;
    logic        reset;
    logic [8:0]  xm;
    logic [8:0]  ym;
    logic [2:0]  btnm;
    logic        m_done_tick;
    logic        frame_tick;
    logic [10:0] cursor_x;
    logic [10:0] cursor_y;
    logic [2:0]  cursor_rgb;
    logic        pending;
    logic [7:0]  pkt_count;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] S_IDLE = 2'd0, S_PEND = 2'd1, S_COMMIT = 2'd2;

    cursor_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .xm          (xm),
        .ym          (ym),
        .btnm        (btnm),
        .m_done_tick (m_done_tick),
        .frame_tick  (frame_tick),
        .cursor_x    (cursor_x),
        .cursor_y    (cursor_y),
        .cursor_rgb  (cursor_rgb),
        .pending     (pending),
        .pkt_count   (pkt_count),
        .dbg_state   (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs; returns 1 time unit after the consuming edge.
    task automatic step(input logic done, input logic frame, input logic [8:0] x,
                        input logic [8:0] y, input logic [2:0] b);
        m_done_tick = done;
        frame_tick  = frame;
        xm          = x;
        ym          = y;
        btnm        = b;
        @(posedge clk);
        #1;
        m_done_tick = 1'b0;
        frame_tick  = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 9'd0, 9'd0, 3'b000);
    endtask

    task automatic pkt(input logic [8:0] x, input logic [8:0] y, input logic [2:0] b);
        step(1'b1, 1'b0, x, y, b);
    endtask

    task automatic frame_commit();
        step(1'b0, 1'b1, 9'd0, 9'd0, 3'b000);
        idle();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #2;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        xm = 9'd0; ym = 9'd0; btnm = 3'b000;
        m_done_tick = 1'b0; frame_tick = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;

        check("rst_x", 16'(cursor_x), 16'd130);
        check("rst_y", 16'(cursor_y), 16'd130);
        check("rst_rgb", 16'(cursor_rgb), 16'd7);
        check("rst_pend", 16'(pending), 16'd0);
        check("rst_cnt", 16'(pkt_count), 16'd0);
        check("rst_state", 16'(dbg_state), 16'(S_IDLE));

        // Basic packet then commit two clocks after frame_tick.
        pkt(9'd10, 9'd5, 3'b001);
        check("p1_pend", 16'(pending), 16'd1);
        check("p1_state", 16'(dbg_state), 16'(S_PEND));
        check("p1_cnt", 16'(pkt_count), 16'd1);
        step(1'b0, 1'b1, 9'd0, 9'd0, 3'b000);
        check("p1_commit_state", 16'(dbg_state), 16'(S_COMMIT));
        check("p1_x_early", 16'(cursor_x), 16'd130);
        idle();
        check("p1_x", 16'(cursor_x), 16'd140);
        check("p1_y", 16'(cursor_y), 16'd125);
        check("p1_rgb", 16'(cursor_rgb), 16'd2);
        check("p1_pend_after", 16'(pending), 16'd0);
        check("p1_idle", 16'(dbg_state), 16'(S_IDLE));

        // frame_tick in IDLE is ignored.
        frame_commit();
        check("idle_frame_x", 16'(cursor_x), 16'd140);
        check("idle_frame_state", 16'(dbg_state), 16'(S_IDLE));

        // Three packets accumulate without a frame.
        do_reset();
        for (int i = 0; i < 3; i++) pkt(9'd1, 9'd0, 3'b000);
        check("acc3_x", 16'(cursor_x), 16'd130);
        check("acc3_pend", 16'(pending), 16'd1);
        check("acc3_cnt", 16'(pkt_count), 16'd3);
        frame_commit();
        check("acc3_commit_x", 16'(cursor_x), 16'd133);
        check("acc3_rgb", 16'(cursor_rgb), 16'd7);

        // Packet coinciding with frame_tick is deferred to the next commit.
        do_reset();
        pkt(9'd2, 9'd0, 3'b010);
        step(1'b1, 1'b1, 9'd4, 9'd0, 3'b100);
        check("ovl_commit_state", 16'(dbg_state), 16'(S_COMMIT));
        check("ovl_commit_pend", 16'(pending), 16'd1);
        idle();
        check("ovl_x", 16'(cursor_x), 16'd132);
        check("ovl_rgb", 16'(cursor_rgb), 16'd4);
        check("ovl_state", 16'(dbg_state), 16'(S_PEND));
        check("ovl_pend", 16'(pending), 16'd1);
        frame_commit();
        check("ovl2_x", 16'(cursor_x), 16'd136);
        check("ovl2_rgb", 16'(cursor_rgb), 16'd0);
        check("ovl2_cnt", 16'(pkt_count), 16'd2);
        check("ovl2_state", 16'(dbg_state), 16'(S_IDLE));

        // Packet arriving in the COMMIT cycle keeps the FSM in PEND.
        pkt(9'd1, 9'd0, 3'b001);
        step(1'b0, 1'b1, 9'd0, 9'd0, 3'b000);
        pkt(9'd3, 9'd0, 3'b001);
        check("cpkt_x", 16'(cursor_x), 16'd137);
        check("cpkt_state", 16'(dbg_state), 16'(S_PEND));
        check("cpkt_pend", 16'(pending), 16'd1);
        frame_commit();
        check("cpkt2_x", 16'(cursor_x), 16'd140);
        check("cpkt2_pend", 16'(pending), 16'd0);

        // Large right motion: accumulator saturates at +2047.
        do_reset();
        for (int i = 0; i < 20; i++) pkt(9'd255, 9'd0, 3'b000);
        check("sat_cnt", 16'(pkt_count), 16'd20);
        frame_commit();
`ifdef CURSOR_WRAP_EN
        check("sat_x", 16'(cursor_x), 16'd314);
`else
        check("sat_x", 16'(cursor_x), 16'd620);
`endif

        // Negative X beyond left edge; unmapped button code gives white.
        do_reset();
        pkt(9'h138, 9'd0, 3'b011);
        frame_commit();
`ifdef CURSOR_WRAP_EN
        check("neg_x", 16'(cursor_x), 16'd551);
`else
        check("neg_x", 16'(cursor_x), 16'd0);
`endif
        check("neg_rgb", 16'(cursor_rgb), 16'd7);

        // Downward motion past the bottom limit.
        do_reset();
        pkt(9'h101, 9'h101, 3'b000);
        pkt(9'd0, 9'h101, 3'b000);
        frame_commit();
`ifdef CURSOR_WRAP_EN
        check("bot_y", 16'(cursor_y), 16'd179);
        check("bot_x", 16'(cursor_x), 16'd496);
`else
        check("bot_y", 16'(cursor_y), 16'd460);
        check("bot_x", 16'(cursor_x), 16'd0);
`endif

        // Upward motion saturating dy at -2048.
        do_reset();
        for (int i = 0; i < 9; i++) pkt(9'd0, 9'd255, 3'b000);
        frame_commit();
`ifdef CURSOR_WRAP_EN
        check("top_y", 16'(cursor_y), 16'd387);
`else
        check("top_y", 16'(cursor_y), 16'd0);
`endif
        check("top_x", 16'(cursor_x), 16'd130);

        // Reset during PEND discards the accumulated motion.
        do_reset();
        pkt(9'd50, 9'd0, 3'b001);
        check("rp_pend", 16'(pending), 16'd1);
        do_reset();
        check("rp_x", 16'(cursor_x), 16'd130);
        check("rp_pend_after", 16'(pending), 16'd0);
        check("rp_state", 16'(dbg_state), 16'(S_IDLE));
        frame_commit();
        check("rp_frame_x", 16'(cursor_x), 16'd130);
        check("rp_frame_rgb", 16'(cursor_rgb), 16'd7);

        // Reset during COMMIT discards the snapshot.
        pkt(9'd50, 9'd0, 3'b001);
        step(1'b0, 1'b1, 9'd0, 9'd0, 3'b000);
        do_reset();
        idle();
        check("rc_x", 16'(cursor_x), 16'd130);
        check("rc_state", 16'(dbg_state), 16'(S_IDLE));

        // Packet counter wraps 255 -> 0.
        do_reset();
        for (int i = 0; i < 255; i++) pkt(9'd0, 9'd0, 3'b000);
        check("cnt_255", 16'(pkt_count), 16'd255);
        pkt(9'd0, 9'd0, 3'b000);
        check("cnt_wrap", 16'(pkt_count), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
